// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe at clk/2, x/y counters, syncs, display window and line/frame pulses.
// Outputs are registered together, so syncs and in_display always line up with pos_x/pos_y; en=0 freezes every output.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_en,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       in_display,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       x_wrap;
    logic       advance;
    logic [9:0] nx;
    logic [9:0] ny;

    // Next position; the decode below uses it so outputs match the counters they are registered with.
    always_comb begin
        x_wrap  = (pos_x == H_LAST);
        advance = en & pix_en;
        nx      = x_wrap ? 10'd0 : pos_x + 10'd1;
        ny      = pos_y;
        if (x_wrap) begin
            ny = (pos_y == V_LAST) ? 10'd0 : pos_y + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_en      <= 1'b0;
            pos_x       <= H_LAST;
            pos_y       <= V_LAST;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            in_display  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                pix_en <= ~pix_en;
            end
            if (advance) begin
                pos_x       <= nx;
                pos_y       <= ny;
                vga_hsync   <= !((nx >= H_SYNC_BEG) && (nx < H_SYNC_END));
                vga_vsync   <= !((ny >= V_SYNC_BEG) && (ny < V_SYNC_END));
                in_display  <= (nx < H_VIS) && (ny < V_VIS);
                line_start  <= x_wrap;
                frame_start <= x_wrap && (pos_y == V_LAST);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing and a tiny-timing instance, expectations queued by cycle and checked by a monitor.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix;
        logic       hs;
        logic       vs;
        logic       disp;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } out_t;

    typedef struct {
        int    cyc;
        bit    inst;
        string name;
        out_t  exp;
    } rec_t;

    localparam bit D = 1'b0;
    localparam bit S = 1'b1;

    logic clk = 1'b0;
    logic rst_d, rst_s, en_d, en_s;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    rec_t sb[$];

    logic       d_pix, d_hs, d_vs, d_disp, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic       s_pix, s_hs, s_vs, s_disp, s_ls, s_fs;
    logic [9:0] s_x, s_y;
    out_t       act_d, act_s;

    assign act_d = {d_pix, d_hs, d_vs, d_disp, d_x, d_y, d_ls, d_fs};
    assign act_s = {s_pix, s_hs, s_vs, s_disp, s_x, s_y, s_ls, s_fs};

    vga_timing_gen u_dut_default (
        .clk(clk), .rst(rst_d), .en(en_d),
        .pix_en(d_pix), .vga_hsync(d_hs), .vga_vsync(d_vs), .in_display(d_disp),
        .pos_x(d_x), .pos_y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_small (
        .clk(clk), .rst(rst_s), .en(en_s),
        .pix_en(s_pix), .vga_hsync(s_hs), .vga_vsync(s_vs), .in_display(s_disp),
        .pos_x(s_x), .pos_y(s_y), .line_start(s_ls), .frame_start(s_fs)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input out_t o);
        return $sformatf("pix=%b hs=%b vs=%b disp=%b x=%0d y=%0d ls=%b fs=%b",
                         o.pix, o.hs, o.vs, o.disp, o.x, o.y, o.ls, o.fs);
    endfunction

    task automatic expect_at(input int c, input bit inst, input string name,
                             input logic pix, input logic hs, input logic vs, input logic disp,
                             input int x, input int y, input logic ls, input logic fs);
        rec_t r;
        r.cyc  = c;
        r.inst = inst;
        r.name = name;
        r.exp  = {pix, hs, vs, disp, 10'(x), 10'(y), ls, fs};
        sb.push_back(r);
    endtask

    task automatic go_to(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    // Monitor: every falling edge, compare all expectations due this cycle.
    always @(negedge clk) begin : monitor
        out_t act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                act = sb[i].inst ? act_s : act_d;
                n_checks++;
                if (act !== sb[i].exp) begin
                    n_errors++;
                    $display("FAIL %s (cycle %0d): got %s, expected %s",
                             sb[i].name, cyc, fmt(act), fmt(sb[i].exp));
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        rst_d = 1'b0;
        rst_s = 1'b0;
        en_d  = 1'b1;
        en_s  = 1'b1;

        // Default 800x525 instance: reset, first frame start, first line.
        expect_at(2,    D, "d_rst_hold",        0, 1, 1, 0, 799, 524, 0, 0);
        expect_at(3,    D, "d_rst_release",     0, 1, 1, 0, 799, 524, 0, 0);
        expect_at(4,    D, "d_first_edge",      1, 1, 1, 0, 799, 524, 0, 0);
        expect_at(5,    D, "d_frame_start",     0, 1, 1, 1, 0,   0,   1, 1);
        expect_at(6,    D, "d_strobe_end",      1, 1, 1, 1, 0,   0,   0, 0);
        expect_at(1283, D, "d_x639",            0, 1, 1, 1, 639, 0,   0, 0);
        expect_at(1285, D, "d_x640_blank",      0, 1, 1, 0, 640, 0,   0, 0);
        expect_at(1315, D, "d_x655",            0, 1, 1, 0, 655, 0,   0, 0);
        expect_at(1317, D, "d_hsync_fall",      0, 0, 1, 0, 656, 0,   0, 0);
        expect_at(1507, D, "d_x751",            0, 0, 1, 0, 751, 0,   0, 0);
        expect_at(1509, D, "d_hsync_rise",      0, 1, 1, 0, 752, 0,   0, 0);
        expect_at(1604, D, "d_line_end",        1, 1, 1, 0, 799, 0,   0, 0);
        expect_at(1605, D, "d_line_start",      0, 1, 1, 1, 0,   1,   1, 0);
        expect_at(1606, D, "d_line_strobe_end", 1, 1, 1, 1, 0,   1,   0, 0);

        // Small 14x7 instance: two and a bit frames.
        expect_at(2,   S, "s_rst_hold",     0, 1, 1, 0, 13, 6, 0, 0);
        expect_at(4,   S, "s_first_edge",   1, 1, 1, 0, 13, 6, 0, 0);
        expect_at(5,   S, "s_frame_start",  0, 1, 1, 1, 0,  0, 1, 1);
        expect_at(19,  S, "s_x7",           0, 1, 1, 1, 7,  0, 0, 0);
        expect_at(21,  S, "s_x8_blank",     0, 1, 1, 0, 8,  0, 0, 0);
        expect_at(25,  S, "s_hsync_fall",   0, 0, 1, 0, 10, 0, 0, 0);
        expect_at(27,  S, "s_x11",          0, 0, 1, 0, 11, 0, 0, 0);
        expect_at(29,  S, "s_hsync_rise",   0, 1, 1, 0, 12, 0, 0, 0);
        expect_at(32,  S, "s_line_end",     1, 1, 1, 0, 13, 0, 0, 0);
        expect_at(33,  S, "s_line1",        0, 1, 1, 1, 0,  1, 1, 0);
        expect_at(89,  S, "s_y3",           0, 1, 1, 1, 0,  3, 1, 0);
        expect_at(117, S, "s_y4_blank",     0, 1, 1, 0, 0,  4, 1, 0);
        expect_at(145, S, "s_vsync_fall",   0, 1, 0, 0, 0,  5, 1, 0);
        expect_at(171, S, "s_vsync_x13",    0, 1, 0, 0, 13, 5, 0, 0);
        expect_at(173, S, "s_vsync_rise",   0, 1, 1, 0, 0,  6, 1, 0);
        expect_at(200, S, "s_frame_end",    1, 1, 1, 0, 13, 6, 0, 0);
        expect_at(201, S, "s_frame2",       0, 1, 1, 1, 0,  0, 1, 1);
        expect_at(341, S, "s_vsync_f2",     0, 1, 0, 0, 0,  5, 1, 0);
        expect_at(397, S, "s_frame3",       0, 1, 1, 1, 0,  0, 1, 1);
        expect_at(463, S, "s_pre_freeze",   0, 1, 1, 1, 5,  2, 0, 0);

        go_to(3);
        n_checks++;
        if (act_d !== {1'b0, 1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL d_rst_direct: got %s", fmt(act_d));
        end
        rst_d = 1'b1;
        rst_s = 1'b1;

        // Freeze the small instance at (5,2) for 37 edges.
        go_to(463);
        en_s = 1'b0;
        expect_at(464, S, "s_frozen_a",     0, 1, 1, 1, 5, 2, 0, 0);
        expect_at(480, S, "s_frozen_b",     0, 1, 1, 1, 5, 2, 0, 0);
        expect_at(500, S, "s_frozen_c",     0, 1, 1, 1, 5, 2, 0, 0);
        expect_at(501, S, "s_resume_edge",  1, 1, 1, 1, 5, 2, 0, 0);
        expect_at(502, S, "s_resume_x6",    0, 1, 1, 1, 6, 2, 0, 0);
        expect_at(506, S, "s_resume_x8",    0, 1, 1, 0, 8, 2, 0, 0);
        expect_at(518, S, "s_resume_line",  0, 1, 1, 1, 0, 3, 1, 0);
        expect_at(519, S, "s_resume_strobe",1, 1, 1, 1, 0, 3, 0, 0);
        go_to(500);
        en_s = 1'b1;

        // Asynchronous reset mid-cycle, then restart.
        expect_at(520, S, "s_async_rst",     0, 1, 1, 0, 13, 6, 0, 0);
        expect_at(521, S, "s_rst_held_a",    0, 1, 1, 0, 13, 6, 0, 0);
        expect_at(522, S, "s_rst_held_b",    0, 1, 1, 0, 13, 6, 0, 0);
        expect_at(523, S, "s_restart_edge",  1, 1, 1, 0, 13, 6, 0, 0);
        expect_at(524, S, "s_restart_frame", 0, 1, 1, 1, 0,  0, 1, 1);
        expect_at(525, S, "s_restart_strobe",1, 1, 1, 1, 0,  0, 0, 0);
        expect_at(526, S, "s_restart_x1",    0, 1, 1, 1, 1,  0, 0, 0);
        go_to(520);
        #4;
        rst_s = 1'b0;
        #1;
        n_checks++;
        if (act_s !== {1'b0, 1'b1, 1'b1, 1'b0, 10'd13, 10'd6, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL s_async_rst_direct: got %s", fmt(act_s));
        end
        go_to(522);
        n_checks++;
        if (act_s !== {1'b0, 1'b1, 1'b1, 1'b0, 10'd13, 10'd6, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL s_rst_held_direct: got %s", fmt(act_s));
        end
        rst_s = 1'b1;

        go_to(1610);
        foreach (sb[i]) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation for cycle %0d never sampled", sb[i].name, sb[i].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
